// File: rtl/rh_axi4_pkg.sv
// rh_axi4_pkg: shared AXI4 encodings, W-channel FSM states and burst legality helper
//   burst_e     : AxBURST encodings (FIXED/INCR/WRAP)
//   resp_e      : xRESP encodings (OKAY/EXOKAY/SLVERR/DECERR)
//   wfsm_e      : write-data sequencer states (IDLE/DATA)
//   BOUNDARY_4K : AXI4 address boundary a burst may not cross
package rh_axi4_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } burst_e;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_e;

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } wfsm_e;

  localparam int unsigned BOUNDARY_4K = 4096;

  // True when a command may not be issued: an INCR burst whose byte span runs past
  // the 4KB page, or a WRAP burst with a beat count other than 2/4/8/16.
  function automatic logic cmd_illegal(input logic [11:0] addr_lo, input logic [7:0] len,
                                       input logic [2:0] size, input logic [1:0] burst);
    logic [16:0] span;
    logic [16:0] last;
    span = 17'(9'(len) + 9'd1) << size;
    last = 17'(addr_lo) + span;
    if (burst == INCR) return last > 17'(BOUNDARY_4K);
    if (burst == WRAP) return !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    return 1'b0;
  endfunction

endpackage

// File: rtl/rh_axi4_if.sv
// rh_axi4_if: AXI4 write-side signal set (AW, W, B channels)
//   master modport : drives AW*/W* payload+valid and BREADY, samples AWREADY/WREADY/B*
//   slave modport  : the mirror image
interface rh_axi4_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 64,
  parameter int unsigned IW = 4
) ();

  logic          AWVALID;
  logic          AWREADY;
  logic [IW-1:0] AWID;
  logic [AW-1:0] AWADDR;
  logic [7:0]    AWLEN;
  logic [2:0]    AWSIZE;
  logic [1:0]    AWBURST;
  logic [3:0]    AWCACHE;
  logic [2:0]    AWPROT;
  logic [3:0]    AWQOS;
  logic [3:0]    AWREGION;
  logic          AWLOCK;

  logic            WVALID;
  logic            WREADY;
  logic [DW-1:0]   WDATA;
  logic [DW/8-1:0] WSTRB;
  logic            WLAST;

  logic          BVALID;
  logic          BREADY;
  logic [IW-1:0] BID;
  logic [1:0]    BRESP;

  modport master (
    output AWVALID, AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWCACHE, AWPROT, AWQOS, AWREGION, AWLOCK,
    input  AWREADY,
    output WVALID, WDATA, WSTRB, WLAST,
    input  WREADY,
    input  BVALID, BID, BRESP,
    output BREADY
  );

  modport slave (
    input  AWVALID, AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWCACHE, AWPROT, AWQOS, AWREGION, AWLOCK,
    output AWREADY,
    input  WVALID, WDATA, WSTRB, WLAST,
    output WREADY,
    output BVALID, BID, BRESP,
    input  BREADY
  );

endinterface

// File: rtl/rh_sync_fifo.sv
// rh_sync_fifo: single-clock FIFO, synchronous active-low reset
//   clk, rst_n    : clock / reset
//   push, wdata   : write request and data (ignored when full)
//   pop, rdata    : read request (ignored when empty); rdata shows the head entry
//   empty, full   : status flags
module rh_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // Storage: no reset needed, only valid entries are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + PW'(1);
      if (do_pop)  rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/rh_axi4_wr_master.sv
// rh_axi4_wr_master: AXI4 write-master engine
//   Accepts a write command plus a beat stream and drives AW/W/B with WLAST generated
//   from the command length; at most MAX_OUTSTANDING bursts are issued but unresponded.
// Ports
//   ACLK, ARESETN          : clock, synchronous active-low reset
//   cmd_*                  : command handshake and AW payload fields
//   cmd_err                : one-cycle pulse when a command is dropped
//   wd_valid/ready/data/strb : upstream write-data stream (no last; WLAST owned here)
//   axi (master)           : AXI4 AW/W/B channels
//   rsp_valid/ready/id/resp: B-channel pass-through to the traffic source
//   outstanding            : issued-but-unresponded burst count
// Build option
//   RH_AXI4_WR_4K_CHECK_EN : drop INCR bursts crossing 4KB and WRAP bursts with illegal length
module rh_axi4_wr_master
  import rh_axi4_pkg::*;
#(
  parameter int unsigned AW              = 32,
  parameter int unsigned DW              = 64,
  parameter int unsigned IW              = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                 ACLK,
  input  logic                                 ARESETN,
  input  logic                                 cmd_valid,
  output logic                                 cmd_ready,
  input  logic [AW-1:0]                        cmd_addr,
  input  logic [7:0]                           cmd_len,
  input  logic [2:0]                           cmd_size,
  input  logic [1:0]                           cmd_burst,
  input  logic [IW-1:0]                        cmd_id,
  input  logic [3:0]                           cmd_cache,
  input  logic [2:0]                           cmd_prot,
  input  logic [3:0]                           cmd_qos,
  input  logic [3:0]                           cmd_region,
  input  logic                                 cmd_lock,
  output logic                                 cmd_err,
  input  logic                                 wd_valid,
  output logic                                 wd_ready,
  input  logic [DW-1:0]                        wd_data,
  input  logic [DW/8-1:0]                      wd_strb,
  rh_axi4_if.master                            axi,
  output logic                                 rsp_valid,
  input  logic                                 rsp_ready,
  output logic [IW-1:0]                        rsp_id,
  output logic [1:0]                           rsp_resp,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  logic       accept;
  logic       drop;
  logic       issue;
  logic       b_hs;
  logic       w_hs;
  logic       fifo_empty;
  logic       fifo_full;
  logic       fifo_pop;
  logic [7:0] fifo_rdata;
  logic [7:0] cur_len;
  logic [7:0] beat_cnt;
  wfsm_e      wstate;

  // A new command may be taken once the AW register is free and the credit limit allows.
  assign cmd_ready = ARESETN && (!axi.AWVALID || axi.AWREADY) &&
                     (outstanding < OW'(MAX_OUTSTANDING));
  assign accept    = cmd_valid && cmd_ready;
  assign issue     = accept && !drop;

`ifdef RH_AXI4_WR_4K_CHECK_EN
  assign drop = cmd_illegal(cmd_addr[11:0], cmd_len, cmd_size, cmd_burst);

  // Drop notification, high for the cycle after the offending handshake.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) cmd_err <= 1'b0;
    else          cmd_err <= accept && drop;
  end
`else
  assign drop    = 1'b0;
  assign cmd_err = 1'b0;
`endif

  // AW channel register: loads on issue, holds until AWREADY.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      axi.AWVALID  <= 1'b0;
      axi.AWID     <= '0;
      axi.AWADDR   <= '0;
      axi.AWLEN    <= '0;
      axi.AWSIZE   <= '0;
      axi.AWBURST  <= '0;
      axi.AWCACHE  <= '0;
      axi.AWPROT   <= '0;
      axi.AWQOS    <= '0;
      axi.AWREGION <= '0;
      axi.AWLOCK   <= 1'b0;
    end else if (issue) begin
      axi.AWVALID  <= 1'b1;
      axi.AWID     <= cmd_id;
      axi.AWADDR   <= cmd_addr;
      axi.AWLEN    <= cmd_len;
      axi.AWSIZE   <= cmd_size;
      axi.AWBURST  <= cmd_burst;
      axi.AWCACHE  <= cmd_cache;
      axi.AWPROT   <= cmd_prot;
      axi.AWQOS    <= cmd_qos;
      axi.AWREGION <= cmd_region;
      axi.AWLOCK   <= cmd_lock;
    end else if (axi.AWREADY) begin
      axi.AWVALID  <= 1'b0;
    end
  end

  // Outstanding credit count; a simultaneous issue and response cancel out.
  assign b_hs = axi.BVALID && axi.BREADY;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      outstanding <= '0;
    end else if (issue && !b_hs) begin
      outstanding <= outstanding + OW'(1);
    end else if (!issue && b_hs && outstanding != '0) begin
      outstanding <= outstanding - OW'(1);
    end
  end

  // Burst lengths in command order; the full guard only matters if a slave
  // answers B before the matching data burst has started.
  assign fifo_pop = (wstate == IDLE) && !fifo_empty;

  rh_sync_fifo #(
    .WIDTH (8),
    .DEPTH (MAX_OUTSTANDING)
  ) u_len_fifo (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .push  (issue),
    .wdata (cmd_len),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // W sequencer: one burst at a time, WLAST on the beat matching the popped length.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wstate   <= IDLE;
      cur_len  <= '0;
      beat_cnt <= '0;
    end else begin
      case (wstate)
        IDLE: begin
          if (!fifo_empty) begin
            wstate   <= DATA;
            cur_len  <= fifo_rdata;
            beat_cnt <= '0;
          end
        end
        DATA: begin
          if (w_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (axi.WLAST) wstate <= IDLE;
          end
        end
        default: wstate <= IDLE;
      endcase
    end
  end

  // Data beats pass straight through while a burst is open.
  assign axi.WVALID = (wstate == DATA) && wd_valid;
  assign wd_ready   = (wstate == DATA) && axi.WREADY;
  assign axi.WDATA  = (wstate == DATA) ? wd_data : '0;
  assign axi.WSTRB  = (wstate == DATA) ? wd_strb : '0;
  assign axi.WLAST  = (wstate == DATA) && (beat_cnt == cur_len);
  assign w_hs       = axi.WVALID && axi.WREADY;

  // Response channel pass-through.
  assign axi.BREADY = rsp_ready;
  assign rsp_valid  = axi.BVALID;
  assign rsp_id     = axi.BID;
  assign rsp_resp   = axi.BRESP;

  logic unused_ok;
  assign unused_ok = fifo_full;

endmodule

// File: tb/tb_rh_axi4_wr_master.sv
// tb_rh_axi4_wr_master: directed bench for rh_axi4_wr_master (AXI slave side driven by hand)
module tb_rh_axi4_wr_master;
  import rh_axi4_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned IW = 4;
  localparam int unsigned MO = 4;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic [3:0]  cmd_id;
  logic [3:0]  cmd_cache;
  logic [2:0]  cmd_prot;
  logic [3:0]  cmd_qos;
  logic [3:0]  cmd_region;
  logic        cmd_lock;
  logic        cmd_err;
  logic        wd_valid;
  logic        wd_ready;
  logic [63:0] wd_data;
  logic [7:0]  wd_strb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_id;
  logic [1:0]  rsp_resp;
  logic [2:0]  outstanding;

  int n_assert = 0;
  int n_fail   = 0;

  rh_axi4_if #(.AW(AW), .DW(DW), .IW(IW)) axi ();

  rh_axi4_wr_master #(
    .AW(AW), .DW(DW), .IW(IW), .MAX_OUTSTANDING(MO)
  ) dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .cmd_size    (cmd_size),
    .cmd_burst   (cmd_burst),
    .cmd_id      (cmd_id),
    .cmd_cache   (cmd_cache),
    .cmd_prot    (cmd_prot),
    .cmd_qos     (cmd_qos),
    .cmd_region  (cmd_region),
    .cmd_lock    (cmd_lock),
    .cmd_err     (cmd_err),
    .wd_valid    (wd_valid),
    .wd_ready    (wd_ready),
    .wd_data     (wd_data),
    .wd_strb     (wd_strb),
    .axi         (axi),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_resp    (rsp_resp),
    .outstanding (outstanding)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_cmd(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
    cmd_addr   = addr;
    cmd_len    = len;
    cmd_size   = 3'd3;
    cmd_burst  = INCR;
    cmd_id     = id;
    cmd_cache  = 4'h3;
    cmd_prot   = 3'h2;
    cmd_qos    = 4'h1;
    cmd_region = 4'h5;
    cmd_lock   = 1'b0;
  endtask

  // Present one command and hold it until taken (bounded).
  task automatic issue(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
    set_cmd(addr, len, id);
    cmd_valid = 1'b1;
    #1;
    for (int i = 0; i < 20 && !cmd_ready; i++) tick();
    check("issue_cmd_ready", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // One B beat with OKAY, taken in a single cycle.
  task automatic respond(input logic [3:0] id);
    axi.BVALID = 1'b1;
    axi.BID    = id;
    axi.BRESP  = OKAY;
    rsp_ready  = 1'b1;
    #1;
    check("rsp_valid", 64'(rsp_valid), 64'd1);
    check("rsp_id", 64'(rsp_id), 64'(id));
    tick();
    axi.BVALID = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int k;
    int acc;
    ARESETN    = 1'b0;
    cmd_valid  = 1'b0;
    set_cmd(32'h0, 8'd0, 4'd0);
    wd_valid   = 1'b0;
    wd_data    = '0;
    wd_strb    = 8'hFF;
    rsp_ready  = 1'b1;
    axi.AWREADY = 1'b0;
    axi.WREADY  = 1'b0;
    axi.BVALID  = 1'b0;
    axi.BID     = '0;
    axi.BRESP   = '0;

    // Reset state
    tick();
    tick();
    check("rst_awvalid", 64'(axi.AWVALID), 64'd0);
    check("rst_awaddr", 64'(axi.AWADDR), 64'd0);
    check("rst_wvalid", 64'(axi.WVALID), 64'd0);
    check("rst_wlast", 64'(axi.WLAST), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_wd_ready", 64'(wd_ready), 64'd0);
    check("rst_cmd_err", 64'(cmd_err), 64'd0);
    check("rst_outstanding", 64'(outstanding), 64'd0);
    ARESETN = 1'b1;
    tick();

    // 1: single beat, AWREADY stalled 3 cycles
    issue(32'h1000, 8'd0, 4'd5);
    for (int i = 0; i < 4; i++) begin
      check("t1_awvalid", 64'(axi.AWVALID), 64'd1);
      check("t1_awaddr", 64'(axi.AWADDR), 64'h1000);
      check("t1_awid", 64'(axi.AWID), 64'd5);
      check("t1_awlen", 64'(axi.AWLEN), 64'd0);
      if (i == 0) begin
        check("t1_cmd_ready_stall", 64'(cmd_ready), 64'd0);
        check("t1_outstanding1", 64'(outstanding), 64'd1);
        check("t1_awcache", 64'(axi.AWCACHE), 64'h3);
        check("t1_awregion", 64'(axi.AWREGION), 64'h5);
      end
      if (i == 3) axi.AWREADY = 1'b1;
      tick();
    end
    axi.AWREADY = 1'b0;
    check("t1_awvalid_done", 64'(axi.AWVALID), 64'd0);
    wd_valid   = 1'b1;
    wd_data    = 64'hA1;
    axi.WREADY = 1'b1;
    #1;
    check("t1_wvalid", 64'(axi.WVALID), 64'd1);
    check("t1_wlast", 64'(axi.WLAST), 64'd1);
    check("t1_wdata", axi.WDATA, 64'hA1);
    check("t1_wstrb", 64'(axi.WSTRB), 64'hFF);
    check("t1_wd_ready", 64'(wd_ready), 64'd1);
    tick();
    wd_valid   = 1'b0;
    axi.WREADY = 1'b0;
    #1;
    check("t1_wvalid_idle", 64'(axi.WVALID), 64'd0);
    respond(4'd5);
    check("t1_rsp_resp", 64'(rsp_resp), 64'd0);
    check("t1_outstanding0", 64'(outstanding), 64'd0);

    // 2: len=3 with WREADY toggling
    axi.AWREADY = 1'b1;
    issue(32'h2000, 8'd3, 4'd2);
    tick();
    k = 0;
    for (int cyc = 0; cyc < 20 && k < 4; cyc++) begin
      wd_valid   = 1'b1;
      wd_data    = 64'h200 + 64'(k);
      axi.WREADY = (cyc % 2 == 0);
      #1;
      check("t2_wvalid", 64'(axi.WVALID), 64'd1);
      if (axi.WREADY) begin
        check("t2_wdata", axi.WDATA, 64'h200 + 64'(k));
        check("t2_wlast", 64'(axi.WLAST), 64'(k == 3));
        k++;
      end
      tick();
    end
    axi.WREADY = 1'b1;
    #1;
    check("t2_no_extra_beat", 64'(axi.WVALID), 64'd0);
    check("t2_beats", 64'(k), 64'd4);
    wd_valid    = 1'b0;
    axi.WREADY  = 1'b0;
    respond(4'd2);
    check("t2_outstanding0", 64'(outstanding), 64'd0);

    // 3: credit limit with B withheld
    axi.AWREADY = 1'b1;
    set_cmd(32'h3000, 8'd0, 4'd3);
    cmd_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (cmd_ready) acc++;
      tick();
    end
    cmd_valid = 1'b0;
    check("t3_accepted", 64'(acc), 64'd4);
    check("t3_outstanding4", 64'(outstanding), 64'd4);
    check("t3_cmd_ready_full", 64'(cmd_ready), 64'd0);
    wd_valid   = 1'b1;
    axi.WREADY = 1'b1;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (axi.WVALID && axi.WREADY) k++;
      tick();
    end
    check("t3_w_bursts", 64'(k), 64'd4);
    respond(4'd3);
    check("t3_outstanding3", 64'(outstanding), 64'd3);
    cmd_valid  = 1'b1;
    axi.BVALID = 1'b1;
    #1;
    check("t3_cmd_ready_b", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid  = 1'b0;
    axi.BVALID = 1'b0;
    check("t3_simul_unchanged", 64'(outstanding), 64'd3);
    issue(32'h3100, 8'd0, 4'd3);
    check("t3_outstanding_refill", 64'(outstanding), 64'd4);
    k = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (axi.WVALID && axi.WREADY) k++;
      tick();
    end
    check("t3_w_refill", 64'(k), 64'd2);
    wd_valid   = 1'b0;
    axi.WREADY = 1'b0;
    axi.BVALID = 1'b1;
    for (int i = 0; i < 10 && outstanding != 3'd0; i++) tick();
    axi.BVALID  = 1'b0;
    axi.AWREADY = 1'b0;
    check("t3_drained", 64'(outstanding), 64'd0);

    // 4: W leads AW
    axi.WREADY = 1'b1;
    issue(32'h4000, 8'd1, 4'd4);
    k = 0;
    for (int i = 0; i < 10; i++) begin
      wd_valid = (k < 2);
      wd_data  = 64'h400 + 64'(k);
      #1;
      if (axi.WVALID && axi.WREADY) begin
        check("t4_wdata", axi.WDATA, 64'h400 + 64'(k));
        check("t4_wlast", 64'(axi.WLAST), 64'(k == 1));
        k++;
      end
      tick();
    end
    wd_valid = 1'b0;
    check("t4_beats_before_aw", 64'(k), 64'd2);
    check("t4_aw_still_pending", 64'(axi.AWVALID), 64'd1);
    axi.AWREADY = 1'b1;
    tick();
    axi.AWREADY = 1'b0;
    check("t4_aw_done", 64'(axi.AWVALID), 64'd0);
    respond(4'd4);
    check("t4_outstanding0", 64'(outstanding), 64'd0);

    // 5: reset in the middle of a len=7 burst
    axi.AWREADY = 1'b1;
    axi.WREADY  = 1'b1;
    issue(32'h5000, 8'd7, 4'd6);
    k = 0;
    for (int i = 0; i < 10 && k < 2; i++) begin
      wd_valid = 1'b1;
      wd_data  = 64'h500 + 64'(k);
      #1;
      if (axi.WVALID && axi.WREADY) k++;
      tick();
    end
    check("t5_two_beats", 64'(k), 64'd2);
    ARESETN = 1'b0;
    tick();
    check("t5_rst_awvalid", 64'(axi.AWVALID), 64'd0);
    check("t5_rst_wvalid", 64'(axi.WVALID), 64'd0);
    check("t5_rst_wlast", 64'(axi.WLAST), 64'd0);
    check("t5_rst_outstanding", 64'(outstanding), 64'd0);
    ARESETN  = 1'b1;
    wd_valid = 1'b0;
    tick();
    issue(32'h6000, 8'd0, 4'd7);
    wd_valid = 1'b1;
    wd_data  = 64'h600;
    k = 0;
    for (int i = 0; i < 10 && k == 0; i++) begin
      #1;
      if (axi.WVALID && axi.WREADY) begin
        check("t5_new_wlast", 64'(axi.WLAST), 64'd1);
        check("t5_new_wdata", axi.WDATA, 64'h600);
        k++;
      end
      tick();
    end
    wd_valid = 1'b0;
    check("t5_new_beat", 64'(k), 64'd1);
    respond(4'd7);
    check("t5_outstanding0", 64'(outstanding), 64'd0);

    // 6: INCR burst crossing 4KB (0xFF0 + 4*8 = 0x1010)
    axi.AWREADY = 1'b0;
    set_cmd(32'hFF0, 8'd3, 4'd8);
    cmd_valid = 1'b1;
    #1;
    check("t6_cmd_ready", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
`ifdef RH_AXI4_WR_4K_CHECK_EN
    check("t6_cmd_err", 64'(cmd_err), 64'd1);
    check("t6_no_aw", 64'(axi.AWVALID), 64'd0);
    check("t6_outstanding", 64'(outstanding), 64'd0);
    tick();
    check("t6_err_pulse_end", 64'(cmd_err), 64'd0);
    check("t6_no_w", 64'(axi.WVALID), 64'd0);
`else
    check("t6_cmd_err", 64'(cmd_err), 64'd0);
    check("t6_awvalid", 64'(axi.AWVALID), 64'd1);
    check("t6_awaddr", 64'(axi.AWADDR), 64'hFF0);
    check("t6_awlen", 64'(axi.AWLEN), 64'd3);
    check("t6_outstanding", 64'(outstanding), 64'd1);
    axi.AWREADY = 1'b1;
    tick();
    axi.AWREADY = 1'b0;
    wd_valid = 1'b1;
    k = 0;
    for (int i = 0; i < 12 && k < 4; i++) begin
      wd_data = 64'hF00 + 64'(k);
      #1;
      if (axi.WVALID && axi.WREADY) begin
        check("t6_wlast", 64'(axi.WLAST), 64'(k == 3));
        k++;
      end
      tick();
    end
    wd_valid = 1'b0;
    check("t6_beats", 64'(k), 64'd4);
    respond(4'd8);
    check("t6_outstanding0", 64'(outstanding), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
